mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//   MEM/WB pipeline register and writeback select, directly downstream of MEMStages.
//   - Captures the data-memory read word, ALU result and destination control at the end of MEM.
//   - Formats load data, selects the writeback source and drives the register-file write port.
//   - Provides a forwarding copy of the writeback value and a retired-instruction counter.
// PARAMETERS
//   XLEN        32  datapath width; equals the width of `data
//   REG_ADDR_W  5   register index width
//   CNT_W       32  retire counter width
// PORTS
//   clk               in   1           clock, rising edge
//   rst               in   1           asynchronous, active-low reset
//   stall_i           in   1           hold the stage contents
//   flush_i           in   1           replace the captured entry with a bubble
//   valid_i           in   1           MEM stage holds a real instruction
//   rdData_i          in   XLEN        data-memory read word (MEMStages rdData)
//   aluResult_i       in   XLEN        ALU result / effective address
//   rdAddr_i          in   REG_ADDR_W  destination register
//   regWriteEnable_i  in   1           instruction writes rd
//   regSelect_i       in   1           1 = writeback from memory, 0 = from ALU
//   funct3_i          in   3           load size/sign code
//   wbData_o          out  XLEN        register-file write data
//   wbAddr_o          out  REG_ADDR_W  register-file write index
//   wbEnable_o        out  1           register-file write strobe
//   valid_o           out  1           WB stage holds a real instruction
//   misalign_o        out  1           misaligned load is in WB (one cycle per entry)
//   retireCount_o     out  CNT_W       count of retired instructions
// BEHAVIOUR
//   - Reset (rst=0, async): all state clears.
//     - valid_o, wbEnable_o and misalign_o are 0.
//     - wbData_o, wbAddr_o and retireCount_o are 0.
//   - Latency is 1 cycle: inputs present at edge N appear on the outputs after edge N.
//   - At each rising edge, priority is flush_i, then stall_i, then normal capture:
//     - flush_i=1: valid_r<=0 and the other fields <=0. Flush wins over stall.
//     - stall_i=1 with flush_i=0: every register holds and the counter does not increment.
//     - Otherwise the registers capture valid_i, rdAddr_i, regWriteEnable_i,
//       misaligned-load flag AND valid_i, and the formatted wbData.
//   - wbData source selection happens before the register:
//     - regSelect_i=1 selects loadFmt(rdData_i).
//     - regSelect_i=0 selects aluResult_i.
//   - wbEnable_o = valid_r & regWrite_r & (wbAddr_r != 0) & ~misalign_r.
//     Writes to x0 are always suppressed.
//   - misalign_o = valid_r & misalign_r.
//   - retireCount_o increments by 1 at an edge where valid_r=1 and stall_i=0.
//     - It counts the instruction leaving WB, including one whose write is suppressed.
//     - It wraps from 2^CNT_W-1 to 0. Flush does not clear it; only reset does.
//   - A bubble (valid_i=0) captured at an edge forces wbEnable_o=0 on the next cycle.
//   - Reset asserted mid-stall or mid-flush forces all outputs to reset values
//     immediately, without waiting for a clock edge.
// CONFIGURATION
//   Macro: MEMWB_LOAD_ALIGN_EN
//   - Defined: loadFmt uses aluResult_i[1:0] as the byte offset.
//     - funct3 000 LB: byte at offset*8, sign-extended.
//     - funct3 100 LBU: byte at offset*8, zero-extended.
//     - funct3 001 LH and 101 LHU: halfword at offset[1]*16, sign- or zero-extended.
//     - funct3 010 LW: the whole word.
//     - A load is misaligned if it is LH/LHU with offset[0]=1, or LW with offset!=0.
//     - Any other funct3 passes the word through unchanged.
//   - Undefined: loadFmt passes the word through unchanged.
//     - misalign_r is tied to 0; funct3_i and aluResult_i[1:0] are ignored for loads.
// TESTING
//   - Reset: rst=0 during traffic -> all outputs 0 asynchronously. After release, one
//     ALU op (aluResult=0x1234, rd=5, valid=1) -> next cycle wbData=0x1234, wbAddr=5,
//     wbEnable=1, retireCount increments to 1 on the following edge.
//   - Write to x0: ALU op with rd=0, value 0xFFFF_FFFF -> wbEnable=0, valid_o=1,
//     retireCount still increments.
//   - Stall then flush: stall_i=1 for 3 cycles -> outputs and counter frozen.
//     Then stall_i=1 with flush_i=1 at the same edge -> valid_o=0, wbEnable=0.
//   - Sub-word loads (MEMWB_LOAD_ALIGN_EN defined): rdData=0x80FF_7F01.
//     - LB at offset 3 -> wbData=0xFFFF_FF80.
//     - LBU at offset 3 -> 0x0000_0080.
//     - LH at offset 2 -> 0xFFFF_80FF.
//     - LW at offset 0 -> 0x80FF_7F01.
//   - Misaligned loads (MEMWB_LOAD_ALIGN_EN defined): LW at offset 1 -> misalign_o=1
//     for one cycle and wbEnable=0. Without the macro, the same LW -> wbData=0x80FF_7F01,
//     wbEnable=1, misalign_o=0.
//   - Counter wrap: CNT_W=4, 17 back-to-back valid instructions -> retireCount reads 1.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: bundles the MEM-side capture bus and the WB-side register-file bus.
// master = upstream pipeline / environment (drives MEM-side, observes WB-side).
// slave  = mem_wb_stage itself (consumes MEM-side, drives WB-side).
interface mem_wb_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  // Pipeline control
  logic                  stall_i;
  logic                  flush_i;
  // MEM-side capture bus
  logic                  valid_i;
  logic [XLEN-1:0]       rdData_i;
  logic [XLEN-1:0]       aluResult_i;
  logic [REG_ADDR_W-1:0] rdAddr_i;
  logic                  regWriteEnable_i;
  logic                  regSelect_i;
  logic [2:0]            funct3_i;
  // WB-side register-file bus
  logic [XLEN-1:0]       wbData_o;
  logic [REG_ADDR_W-1:0] wbAddr_o;
  logic                  wbEnable_o;
  logic                  valid_o;
  logic                  misalign_o;
  logic [CNT_W-1:0]      retireCount_o;

  modport master (
    output stall_i, flush_i, valid_i, rdData_i, aluResult_i, rdAddr_i,
           regWriteEnable_i, regSelect_i, funct3_i,
    input  wbData_o, wbAddr_o, wbEnable_o, valid_o, misalign_o, retireCount_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, rdData_i, aluResult_i, rdAddr_i,
           regWriteEnable_i, regSelect_i, funct3_i,
    output wbData_o, wbAddr_o, wbEnable_o, valid_o, misalign_o, retireCount_o
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register, load formatting, writeback select, retire counter.
// Latency: 1 cycle from MEM-side inputs to WB-side outputs.
// Backpressure: stall_i holds every register and the counter; flush_i (wins over stall) inserts a bubble.
// Ports: clk, rst (async active-low); bus (mem_wb_stage_if.slave) carries stall/flush,
//   the MEM-side capture signals and the register-file write port + forwarding/retire outputs.
// Option macro MEMWB_LOAD_ALIGN_EN: byte/halfword load extraction and misalignment detection;
//   when undefined the memory word passes through and misalignment is never flagged.
module mem_wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_wb_stage_if.slave       bus
);

  logic                  valid_q, valid_d;
  logic                  regwr_q, regwr_d;
  logic                  mis_q, mis_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [XLEN-1:0]       load_data;
  logic                  load_mis;

`ifdef MEMWB_LOAD_ALIGN_EN
  logic [1:0]      off;
  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  always_comb begin
    off       = bus.aluResult_i[1:0];
    byte_sh   = bus.rdData_i >> {off, 3'b000};
    half_sh   = bus.rdData_i >> {off[1], 4'b0000};
    ld_byte   = byte_sh[7:0];
    ld_half   = half_sh[15:0];
    load_data = bus.rdData_i;
    load_mis  = 1'b0;
    case (bus.funct3_i)
      3'b000: load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100: load_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001: begin
        load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
        load_mis  = off[0];
      end
      3'b101: begin
        load_data = {{(XLEN-16){1'b0}}, ld_half};
        load_mis  = off[0];
      end
      3'b010: load_mis = (off != 2'b00);
      default: ;
    endcase
  end
`else
  // Sub-word formatting disabled: load size code is irrelevant.
  logic unused_funct3;
  assign unused_funct3 = ^bus.funct3_i;

  always_comb begin
    load_data = bus.rdData_i;
    load_mis  = 1'b0;
  end
`endif

  always_comb begin
    valid_d = valid_q;
    regwr_d = regwr_q;
    mis_d   = mis_q;
    addr_d  = addr_q;
    data_d  = data_q;
    // The instruction sitting in WB leaves whenever the stage is not stalled.
    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, (valid_q & ~bus.stall_i)};
    if (bus.flush_i) begin
      valid_d = 1'b0;
      regwr_d = 1'b0;
      mis_d   = 1'b0;
      addr_d  = '0;
      data_d  = '0;
    end else if (!bus.stall_i) begin
      valid_d = bus.valid_i;
      regwr_d = bus.regWriteEnable_i;
      // Only memory-sourced writebacks are loads; ALU ops reuse funct3 for other meanings.
      mis_d   = load_mis & bus.regSelect_i & bus.valid_i;
      addr_d  = bus.rdAddr_i;
      data_d  = bus.regSelect_i ? load_data : bus.aluResult_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      regwr_q <= 1'b0;
      mis_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      regwr_q <= regwr_d;
      mis_q   <= mis_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.wbData_o      = data_q;
  assign bus.wbAddr_o      = addr_q;
  assign bus.wbEnable_o    = valid_q & regwr_q & (addr_q != '0) & ~mis_q;
  assign bus.valid_o       = valid_q;
  assign bus.misalign_o    = valid_q & mis_q;
  assign bus.retireCount_o = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  localparam int CW = 4;
`ifdef MEMWB_LOAD_ALIGN_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_wb_stage_if #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(CW)) bus ();

  mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, flush, valid;
    logic [31:0] rd_data, alu;
    logic [4:0]  rd;
    logic        we, sel;
    logic [2:0]  f3;
    logic        e_valid;
    logic [31:0] e_data;
    logic [4:0]  e_addr;
    logic        e_en, e_mis;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic stall, flush, valid, input logic [31:0] rd_data, alu,
    input logic [4:0] rd, input logic we, sel, input logic [2:0] f3,
    input logic e_valid, input logic [31:0] e_data, input logic [4:0] e_addr,
    input logic e_en, e_mis, input logic [3:0] e_cnt);
    vec_t v;
    v.stall = stall; v.flush = flush; v.valid = valid; v.rd_data = rd_data; v.alu = alu;
    v.rd = rd; v.we = we; v.sel = sel; v.f3 = f3;
    v.e_valid = e_valid; v.e_data = e_data; v.e_addr = e_addr;
    v.e_en = e_en; v.e_mis = e_mis; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_valid, input logic [31:0] e_data,
                         input logic [4:0] e_addr, input logic e_en, input logic e_mis,
                         input logic [3:0] e_cnt);
    chk({tag, ".valid"}, {31'b0, bus.valid_o}, {31'b0, e_valid});
    chk({tag, ".data"},  bus.wbData_o, e_data);
    chk({tag, ".addr"},  {27'b0, bus.wbAddr_o}, {27'b0, e_addr});
    chk({tag, ".en"},    {31'b0, bus.wbEnable_o}, {31'b0, e_en});
    chk({tag, ".mis"},   {31'b0, bus.misalign_o}, {31'b0, e_mis});
    chk({tag, ".cnt"},   {28'b0, bus.retireCount_o}, {28'b0, e_cnt});
  endtask

  task automatic drive(input logic stall, flush, valid, input logic [31:0] rd_data, alu,
                       input logic [4:0] rd, input logic we, sel, input logic [2:0] f3);
    bus.stall_i = stall; bus.flush_i = flush; bus.valid_i = valid;
    bus.rdData_i = rd_data; bus.aluResult_i = alu; bus.rdAddr_i = rd;
    bus.regWriteEnable_i = we; bus.regSelect_i = sel; bus.funct3_i = f3;
  endtask

  localparam logic [31:0] W = 32'h80FF_7F01;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    //            stl fl  v  rdData alu          rd we sel f3      ev data                          addr en              mis        cnt
    vecs.push_back(mk(0, 0, 1, 0, 32'h1234,      5, 1, 0, 3'b000,  1, 32'h1234,                     5,  1,              0,         0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h55,        7, 1, 0, 3'b000,  0, 32'h55,                       7,  0,              0,         1));
    vecs.push_back(mk(0, 0, 1, 0, 32'hFFFF_FFFF, 0, 1, 0, 3'b000,  1, 32'hFFFF_FFFF,                0,  0,              0,         1));
    vecs.push_back(mk(0, 0, 1, 0, 32'hA5A5_0000, 10,0, 0, 3'b000,  1, 32'hA5A5_0000,                10, 0,              0,         2));
    vecs.push_back(mk(0, 0, 1, W, 32'h1003,      1, 1, 1, 3'b000,  1, AL ? 32'hFFFF_FF80 : W,       1,  1,              0,         3));
    vecs.push_back(mk(0, 0, 1, W, 32'h2003,      2, 1, 1, 3'b100,  1, AL ? 32'h0000_0080 : W,       2,  1,              0,         4));
    vecs.push_back(mk(0, 0, 1, W, 32'h2002,      3, 1, 1, 3'b001,  1, AL ? 32'hFFFF_80FF : W,       3,  1,              0,         5));
    vecs.push_back(mk(0, 0, 1, W, 32'h2002,      4, 1, 1, 3'b101,  1, AL ? 32'h0000_80FF : W,       4,  1,              0,         6));
    vecs.push_back(mk(0, 0, 1, W, 32'h3000,      6, 1, 1, 3'b010,  1, W,                            6,  1,              0,         7));
    vecs.push_back(mk(0, 0, 1, W, 32'h3000,      8, 1, 1, 3'b000,  1, AL ? 32'h0000_0001 : W,       8,  1,              0,         8));
    vecs.push_back(mk(0, 0, 1, W, 32'h3001,      9, 1, 1, 3'b010,  1, W,                            9,  !AL,            AL,        9));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         9, 0, 0, 3'b000,  0, 32'h0,                        9,  0,              0,         10));
    vecs.push_back(mk(0, 0, 1, 0, 32'hCAFE,      11,1, 0, 3'b000,  1, 32'hCAFE,                     11, 1,              0,         10));
    vecs.push_back(mk(1, 0, 1, 0, 32'hDEAD,      12,1, 0, 3'b000,  1, 32'hCAFE,                     11, 1,              0,         10));
    vecs.push_back(mk(1, 0, 1, 0, 32'hDEAD,      12,1, 0, 3'b000,  1, 32'hCAFE,                     11, 1,              0,         10));
    vecs.push_back(mk(1, 0, 1, 0, 32'hDEAD,      12,1, 0, 3'b000,  1, 32'hCAFE,                     11, 1,              0,         10));
    vecs.push_back(mk(1, 1, 1, 0, 32'hBEEF,      13,1, 0, 3'b000,  0, 32'h0,                        0,  0,              0,         10));
    vecs.push_back(mk(0, 0, 1, 0, 32'h7,         14,1, 0, 3'b000,  1, 32'h7,                        14, 1,              0,         10));
    vecs.push_back(mk(0, 1, 1, 0, 32'h9,         15,1, 0, 3'b000,  0, 32'h0,                        0,  0,              0,         11));
    vecs.push_back(mk(0, 0, 1, W, 32'h1,         16,1, 1, 3'b001,  1, AL ? 32'h0000_7F01 : W,       16, !AL,            AL,        11));

    // Reset state
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].rd_data, vecs[i].alu,
            vecs[i].rd, vecs[i].we, vecs[i].sel, vecs[i].f3);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data, vecs[i].e_addr,
              vecs[i].e_en, vecs[i].e_mis, vecs[i].e_cnt);
    end

    // Asynchronous reset in the middle of a stall
    @(negedge clk);
    drive(1, 0, 1, 0, 32'h4444, 17, 1, 0, 3'b000);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_all("rst_stall", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 1, 0, 32'h5555, 18, 1, 0, 3'b000);
    @(posedge clk);
    #1;
    chk_all("post_rst", 1, 32'h5555, 18, 1, 0, 0);

    // Asynchronous reset while a flush is pending
    @(negedge clk);
    drive(0, 1, 1, 0, 32'h6666, 19, 1, 0, 3'b000);
    #2;
    rst = 1'b0;
    #1;
    chk_all("rst_flush", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3'b000);

    // Counter wrap with a 4-bit counter: 17 back-to-back retirements
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      drive(0, 0, 1, 0, k, 5'(k), 1, 0, 3'b000);
      @(posedge clk);
      #1;
      if (k == 16) chk("wrap_max", {28'b0, bus.retireCount_o}, 32'd15);
      if (k == 17) chk("wrap_zero", {28'b0, bus.retireCount_o}, 32'd0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    @(posedge clk);
    #1;
    chk("wrap_one", {28'b0, bus.retireCount_o}, 32'd1);
    chk("wrap_bubble_en", {31'b0, bus.wbEnable_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
